// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter controller: FSM states, command opcodes
// and the tick-period helper used to size the prescaler.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_CLEAR = 2'd3
  } op_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int PRESC_W = 32;

  // A shift that underflows to zero must still tick, hence the floor of one.
  function automatic logic [PRESC_W-1:0] tick_period(input logic [PRESC_W-1:0] base,
                                                      input logic [3:0] rate);
    logic [PRESC_W-1:0] p;
    p = base >> rate;
    return (p == '0) ? {{(PRESC_W-1){1'b0}}, 1'b1} : p;
  endfunction

endpackage

// File: rtl/counter_ctrl_tick.sv
// Free-running divider: counts 0..period-1 while enabled and flags the last
// count, wrapping to zero on that cycle.
module tick_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = PRESC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic             at_end;

  assign at_end = (count == (period - CNT_W'(1)));
  assign tick   = enable && at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_end ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven counter controller: accepts START/STOP/CLEAR, paces
// increments through a prescaler and raises a sticky terminal-count flag.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int clk_freq  = 125_000_000,
  parameter int BIT_WIDTH = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cfg_rate,
  input  logic [BIT_WIDTH:0] cfg_limit,
  input  logic               cfg_autoreload,
  input  logic               irq_ack,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic [BIT_WIDTH:0] count_out,
  output logic [1:0]         state_out,
  output logic               done_irq
);

  logic [1:0]         state;
  logic [3:0]         rate_q;
  logic [BIT_WIDTH:0] limit_q;
  logic               autoreload_q;

  logic               cmd_fire;
  logic               do_clear;
  logic               do_start;
  logic               do_stop;
  logic               load_start;
  logic               resume;
  logic               tick;
  logic               terminal;
  logic [PRESC_W-1:0] period;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign do_clear   = cmd_fire && (cmd_op == OP_CLEAR);
  assign do_start   = cmd_fire && (cmd_op == OP_START);
  assign do_stop    = cmd_fire && (cmd_op == OP_STOP);
  assign load_start = do_start && ((state == S_IDLE) || (state == S_DONE));
  assign resume     = do_start && (state == S_PAUSE);

  assign period = tick_period(clk_freq, rate_q);

  // Only a loading START or CLEAR rewinds the prescaler; PAUSE keeps its phase.
  tick_prescaler #(
    .CNT_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (state == S_RUN),
    .clear  (do_clear || load_start),
    .period (period),
    .tick   (tick)
  );

  // CLEAR and reset both suppress a tick landing in the same cycle.
  assign cnt_en    = tick && !do_clear && !rst;
  assign terminal  = cnt_en && (count_out == limit_q);
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count_out    <= '0;
      cnt_clr      <= 1'b0;
      done_irq     <= 1'b0;
      cmd_ready    <= 1'b1;
      rate_q       <= '0;
      limit_q      <= '0;
      autoreload_q <= 1'b0;
    end else begin
      cmd_ready <= !cmd_fire;
      cnt_clr   <= do_clear;

      if (terminal) begin
        done_irq <= 1'b1;
      end else if (irq_ack) begin
        done_irq <= 1'b0;
      end

      if (do_clear) begin
        state     <= S_IDLE;
        count_out <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (load_start) begin
              state        <= S_RUN;
              count_out    <= '0;
              rate_q       <= cfg_rate;
              limit_q      <= cfg_limit;
              autoreload_q <= cfg_autoreload;
            end
          end
          S_RUN: begin
            if (terminal) begin
              if (autoreload_q) begin
                count_out <= '0;
              end
            end else if (cnt_en) begin
              count_out <= count_out + 1'b1;
            end
            // A terminal stop outranks a STOP arriving on the same edge.
            if (terminal && !autoreload_q) begin
              state <= S_DONE;
            end else if (do_stop) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (resume) begin
              state <= S_RUN;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl (clk_freq=8, BIT_WIDTH=7): directed table, corner
// sequences and random traffic, all checked against a tick-counting model.
module tb_counter_ctrl;

  localparam int FREQ = 8;
  localparam int BW   = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cfg_rate;
  logic [BW:0]   cfg_limit;
  logic          cfg_autoreload;
  logic          irq_ack;
  logic          cnt_en;
  logic          cnt_clr;
  logic [BW:0]   count_out;
  logic [1:0]    state_out;
  logic          done_irq;

  counter_ctrl #(
    .clk_freq  (FREQ),
    .BIT_WIDTH (BW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cfg_rate       (cfg_rate),
    .cfg_limit      (cfg_limit),
    .cfg_autoreload (cfg_autoreload),
    .irq_ack        (irq_ack),
    .cnt_en         (cnt_en),
    .cnt_clr        (cnt_clr),
    .count_out      (count_out),
    .state_out      (state_out),
    .done_irq       (done_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: run/pause/done flags, RUN cycles and ticks since the last load.
  bit m_run, m_pause, m_done, m_irq, m_ready, m_clr, m_ar;
  int m_cycles, m_ticks, m_rate, m_limit;

  logic s_cnt_en, s_cnt_clr, s_ready;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] rate;
    logic [7:0] limit;
    logic       ar;
    logic       ack;
    int         idle;
    logic [1:0] e_state;
    logic [7:0] e_count;
    logic       e_irq;
  } vec_t;

  vec_t tbl [13];

  function automatic int period_of(input int r);
    int p;
    p = FREQ >> r;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic bit model_tick();
    return m_run && ((m_cycles % period_of(m_rate)) == period_of(m_rate) - 1);
  endfunction

  function automatic int exp_count();
    if (m_ar) return m_ticks % (m_limit + 1);
    return (m_ticks < m_limit) ? m_ticks : m_limit;
  endfunction

  function automatic int exp_state();
    if (m_done)  return 3;
    if (m_pause) return 2;
    if (m_run)   return 1;
    return 0;
  endfunction

  task automatic reset_model();
    m_run = 0; m_pause = 0; m_done = 0; m_irq = 0; m_ready = 1; m_clr = 0;
    m_ar = 0; m_cycles = 0; m_ticks = 0; m_rate = 0; m_limit = 0;
  endtask

  task automatic step_model(input bit r, input bit v, input logic [1:0] op,
                            input logic [3:0] rate, input logic [7:0] lim,
                            input bit ar, input bit ack);
    bit acc, clr, tk, term, set_irq;
    if (r) begin
      reset_model();
    end else begin
      acc = v && m_ready;
      clr = acc && (op == 2'd3);
      set_irq = 0;
      if (clr) begin
        m_run = 0; m_pause = 0; m_done = 0; m_ticks = 0; m_cycles = 0;
      end else if (m_run) begin
        tk = model_tick();
        m_cycles++;
        if (tk) begin
          term = (m_ticks % (m_limit + 1)) == m_limit;
          m_ticks++;
          if (term) begin
            set_irq = 1;
            if (!m_ar) begin
              m_run = 0; m_done = 1;
            end
          end
        end
        if (acc && op == 2'd2 && m_run) begin
          m_run = 0; m_pause = 1;
        end
      end else if (acc && op == 2'd1) begin
        if (m_pause) begin
          m_pause = 0; m_run = 1;
        end else begin
          m_rate = int'(rate); m_limit = int'(lim); m_ar = ar;
          m_ticks = 0; m_cycles = 0; m_run = 1; m_done = 0;
        end
      end
      m_irq   = set_irq ? 1'b1 : (ack ? 1'b0 : m_irq);
      m_ready = !acc;
      m_clr   = clr;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare at negedge against the model, advance.
  task automatic apply_stimulus(input bit r, input bit v, input logic [1:0] op,
                                input logic [3:0] rate, input logic [7:0] lim,
                                input bit ar, input bit ack);
    rst = r; cmd_valid = v; cmd_op = op; cfg_rate = rate;
    cfg_limit = lim; cfg_autoreload = ar; irq_ack = ack;
    @(negedge clk);
    s_cnt_en = cnt_en; s_cnt_clr = cnt_clr; s_ready = cmd_ready;
    check_output("cnt_en", 32'(cnt_en),
                 32'(!r && model_tick() && !(v && m_ready && op == 2'd3)));
    check_output("state_out", 32'(state_out), exp_state());
    check_output("count_out", 32'(count_out), exp_count());
    check_output("done_irq", 32'(done_irq), 32'(m_irq));
    check_output("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    check_output("cnt_clr", 32'(cnt_clr), 32'(m_clr));
    step_model(r, v, op, rate, lim, ar, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] rate, input logic [7:0] lim, input bit ar);
    apply_stimulus(1'b0, 1'b1, op, rate, lim, ar, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    bit r, v, ar, ack;
    logic [1:0] op;

    //            v  op rate lim ar ack idle  state count irq
    tbl[0]  = '{1'b1, 2'd1, 4'd0, 8'd3, 1'b0, 1'b0, 0, 2'd1, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 6, 2'd1, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 0, 2'd1, 8'd1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 7, 2'd1, 8'd2, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 7, 2'd1, 8'd3, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 7, 2'd3, 8'd3, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b1, 0, 2'd3, 8'd3, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 4'd0, 8'd0, 1'b0, 1'b0, 1, 2'd0, 8'd0, 1'b0};
    tbl[8]  = '{1'b1, 2'd1, 4'd3, 8'd2, 1'b1, 1'b0, 0, 2'd1, 8'd0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1, 2'd1, 8'd2, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0, 0, 2'd1, 8'd0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b1, 0, 2'd1, 8'd1, 1'b0};
    tbl[12] = '{1'b1, 2'd3, 4'd0, 8'd0, 1'b0, 1'b0, 1, 2'd0, 8'd0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cfg_rate = 4'd0;
    cfg_limit = 8'd0; cfg_autoreload = 1'b0; irq_ack = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b0, tbl[i].v, tbl[i].op, tbl[i].rate, tbl[i].limit, tbl[i].ar, tbl[i].ack);
      nop(tbl[i].idle);
      check_output($sformatf("tbl%0d_state", i), 32'(state_out), 32'(tbl[i].e_state));
      check_output($sformatf("tbl%0d_count", i), 32'(count_out), 32'(tbl[i].e_count));
      check_output($sformatf("tbl%0d_irq", i), 32'(done_irq), 32'(tbl[i].e_irq));
    end

    // Pause keeps the prescaler phase; resume ticks two cycles later.
    cmd(2'd1, 4'd1, 8'd100, 1'b0);
    nop(1);
    cmd(2'd2, 4'd0, 8'd0, 1'b0);
    check_output("pause_state", 32'(state_out), 32'd2);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      nop(1);
      if (s_cnt_en) seen = 1;
    end
    check_output("pause_no_cnt_en", 32'(seen), 32'd0);
    cmd(2'd1, 4'd0, 8'd0, 1'b0);
    nop(1);
    check_output("resume_first_cycle_cnt_en", 32'(s_cnt_en), 32'd0);
    nop(1);
    check_output("resume_second_cycle_cnt_en", 32'(s_cnt_en), 32'd1);
    check_output("resume_count", 32'(count_out), 32'd1);

    // CLEAR lands exactly on a tick cycle.
    nop(3);
    cmd(2'd3, 4'd0, 8'd0, 1'b0);
    check_output("clear_tick_cnt_en", 32'(s_cnt_en), 32'd0);
    nop(1);
    check_output("clear_cnt_clr", 32'(s_cnt_clr), 32'd1);
    check_output("clear_state", 32'(state_out), 32'd0);
    check_output("clear_count", 32'(count_out), 32'd0);

    // Back-to-back commands: the second is held until cmd_ready returns.
    cmd(2'd1, 4'd0, 8'd200, 1'b0);
    cmd(2'd2, 4'd0, 8'd0, 1'b0);
    check_output("b2b_ready_low", 32'(s_ready), 32'd0);
    check_output("b2b_still_run", 32'(state_out), 32'd1);
    cmd(2'd2, 4'd0, 8'd0, 1'b0);
    check_output("b2b_paused", 32'(state_out), 32'd2);
    nop(1);
    cmd(2'd3, 4'd0, 8'd0, 1'b0);
    nop(1);

    // irq_ack coincides with a terminal tick on limit 0.
    cmd(2'd1, 4'd3, 8'd0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    check_output("ack_vs_set_cnt_en", 32'(s_cnt_en), 32'd1);
    check_output("ack_vs_set_irq", 32'(done_irq), 32'd1);
    check_output("limit0_count", 32'(count_out), 32'd0);
    check_output("limit0_state", 32'(state_out), 32'd1);

    // Reset in the middle of a run.
    apply_stimulus(1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    check_output("rst_cnt_en", 32'(s_cnt_en), 32'd0);
    check_output("rst_state", 32'(state_out), 32'd0);
    check_output("rst_count", 32'(count_out), 32'd0);
    check_output("rst_irq", 32'(done_irq), 32'd0);
    check_output("rst_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_cnt_clr", 32'(cnt_clr), 32'd0);

    for (int i = 0; i < 2500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 2'd1;
        4, 5:       op = 2'd2;
        6:          op = 2'd3;
        default:    op = 2'd0;
      endcase
      ar  = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 7) == 0);
      apply_stimulus(r, v, op, 4'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), ar, ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter clk_freq, default 125_000_000, input clock frequency in Hz; prescaler base period in cycles.
REQ-002 Parameter BIT_WIDTH, default 31, MSB index of count path; count width = BIT_WIDTH+1.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port cmd_valid  in  1  command offered.
REQ-006 Port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready on a rising edge.
REQ-007 Port cmd_op  in  2  0 NOP, 1 START, 2 STOP, 3 CLEAR.
REQ-008 Port cfg_rate  in  4  rate select; sampled only when a loading START is accepted.
REQ-009 Port cfg_limit  in  BIT_WIDTH+1  terminal count; sampled only when a loading START is accepted.
REQ-010 Port cfg_autoreload  in  1  1 = wrap at terminal and keep running; sampled with cfg_limit.
REQ-011 Port irq_ack  in  1  clears done_irq.
REQ-012 Port cnt_en  out  1  one-cycle increment strobe to the counter datapath.
REQ-013 Port cnt_clr  out  1  one-cycle clear strobe to the counter datapath.
REQ-014 Port count_out  out  BIT_WIDTH+1  controller shadow count.
REQ-015 Port state_out  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-016 Port done_irq  out  1  sticky terminal-count flag.

Function
REQ-017 Tick period P SHALL be max(1, clk_freq >> rate_q), rate_q = latched cfg_rate; prescaler counts 0..P-1 only in RUN, cnt_en high in the cycle prescaler == P-1, then prescaler wraps to 0.
REQ-018 Each cnt_en SHALL increment count_out by 1 in the same edge, except at terminal (REQ-019).
REQ-019 Terminal: cnt_en while count_out == limit_q -> done_irq set; autoreload_q=1: count_out <= 0, stay RUN; else count_out holds, state <= DONE.
REQ-020 IDLE: START -> RUN, latch cfg, prescaler <= 0, count_out <= 0; STOP, NOP ignored; CLEAR -> cnt_clr pulse, stay IDLE.
REQ-021 RUN: STOP -> PAUSE, prescaler holds; CLEAR -> IDLE; START ignored.
REQ-022 PAUSE: START -> RUN, resume without reloading cfg or prescaler; CLEAR -> IDLE; STOP ignored.
REQ-023 DONE: START -> RUN as loading START (REQ-020); CLEAR -> IDLE; STOP ignored.
REQ-024 CLEAR accepted in any state SHALL pulse cnt_clr next cycle, count_out <= 0, prescaler <= 0, state <= IDLE; done_irq unaffected.
REQ-025 Same-cycle tick and STOP: increment/terminal processed first, then PAUSE (if not DONE); tick and CLEAR: CLEAR wins, no cnt_en.
REQ-026 cmd_ready SHALL be 1 except the single cycle following any accepted command (one command per two cycles max).
REQ-027 done_irq set has priority over simultaneous irq_ack.
REQ-028 Latency: START accepted at edge N -> state_out RUN from N; first cnt_en P cycles after acceptance.
REQ-029 limit_q = 0: terminal on first tick.

Reset
REQ-030 rst SHALL set state IDLE, count_out 0, prescaler 0, cnt_en 0, cnt_clr 0, done_irq 0, cmd_ready 1, rate_q 0, limit_q 0, autoreload_q 0.
REQ-031 rst asserted mid-RUN SHALL abort immediately with no cnt_en in the reset cycle; rst dominates all inputs.

Structure
REQ-032 Package counter_ctrl_pkg SHALL hold state enum (2-bit), op enum (2-bit) and op encoding constants.
REQ-033 Prescaler SHALL be one sub-module tick_prescaler (enable, clear, period in, tick out); FSM and count in counter_ctrl.

Verification (clk_freq=8, BIT_WIDTH=7)
REQ-034 START rate=0 limit=3 autoreload=0 -> cnt_en every 8 cycles, count_out 1,2,3, state DONE after 4th tick, done_irq=1.
REQ-035 START rate=3 limit=2 autoreload=1 -> cnt_en every cycle, count_out 1,2,0,1..., done_irq set at wrap, stays RUN.
REQ-036 RUN rate=1, STOP after 2 cycles, wait 20, START -> no cnt_en during PAUSE, first tick 2 cycles after resume.
REQ-037 CLEAR same cycle as tick -> no cnt_en, cnt_clr pulse, count_out 0, IDLE.
REQ-038 Back-to-back cmd_valid -> second command held until cmd_ready returns high; irq_ack with terminal same cycle -> done_irq stays 1.
REQ-039 rst asserted mid-RUN -> all outputs at REQ-030 values next cycle.
